// File: rtl/uart_pkg.sv
// Shared UART definitions for the host-link transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    // 32.256 MHz / 280 = 115200 baud
    localparam int unsigned CLKS_PER_BIT_115200 = 280;

    function automatic logic calc_parity(input logic [7:0]  data,
                                         input int unsigned data_bits,
                                         input int unsigned mode);
        logic p;
        p = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < data_bits) begin
                p = p ^ data[i];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last and next-to-last cycle.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic PRE_AT_ZERO = (CLKS_PER_BIT == 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_q + CNT_W'(1);
        if (clear_i || (cnt_q == LAST)) begin
            cnt_next = '0;
        end
    end

    // Flags are registered from the next count so they align with cnt_q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            tick_o     <= 1'b0;
            pre_tick_o <= PRE_AT_ZERO;
        end else begin
            cnt_q      <= cnt_next;
            tick_o     <= (cnt_next == LAST);
            pre_tick_o <= (cnt_next == PRE_LAST);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: ready/valid byte in, start/data/parity/stop frame out on tx_o.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic        tick;
    logic        pre_tick;
    logic        accept;

    assign accept = valid_i && ready_o;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state == IDLE),
        .tick_o    (tick),
        .pre_tick_o(pre_tick)
    );

    // Accept is only possible in IDLE or the final stop cycle, so it takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            tx_o     <= 1'b1;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
        end else if (accept) begin
            state    <= START;
            bit_cnt  <= 3'd0;
            shift_q  <= data_i;
            parity_q <= calc_parity(data_i, DATA_BITS, PARITY);
            tx_o     <= 1'b0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_o    <= 1'b1;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                        tx_o    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= 3'd0;
                            if (PARITY != PARITY_NONE) begin
                                state <= uart_pkg::PARITY;
                                tx_o  <= parity_q;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_o    <= shift_q[1];
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (tick) begin
                        state   <= STOP;
                        bit_cnt <= 3'd0;
                        tx_o    <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            ready_o <= 1'b1;
                            busy_o  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (pre_tick && (bit_cnt == LAST_STOP)) begin
                        // Open the handshake for the final stop cycle to chain frames
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_o    <= 1'b1;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
